// File: rtl/mem_map_pkg.sv
// Memory map shared by the data-side responder and anything that decodes
// cpu data addresses.
//   REG_*            word offsets inside the MMIO window (dataAddr[3:2])
//   MMIO_NIBBLE_DEF  default dataAddr[31:28] value selecting the MMIO window
//   halt_state_t     run/halt state of the responder
package mem_map_pkg;

  localparam logic [1:0] REG_CYCLE = 2'd0;
  localparam logic [1:0] REG_GPIO  = 2'd1;
  localparam logic [1:0] REG_HALT  = 2'd2;
  localparam logic [1:0] REG_RSVD  = 2'd3;

  localparam logic [3:0] MMIO_NIBBLE_DEF = 4'h8;

  typedef enum logic {RUN, HALT} halt_state_t;

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
// Ports:
//   clk    rising-edge write clock
//   we     write strobe
//   waddr  write word index
//   wdata  write data
//   raddr  read word index
//   rdata  read data, combinational from raddr
module data_ram #(
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side responder for the single-cycle cpu: data RAM plus a small MMIO
// window (cycle counter, GPIO output, halt/tohost register).
// Ports:
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   dataAddr   byte address from cpu, bits [1:0] ignored
//   writeData  store data from cpu
//   we         store strobe from cpu
//   readData   load data, combinational from dataAddr (pre-edge state)
//   gpio_out   GPIO register contents
//   halted     high once the halt register has been written
//   halt_code  value captured by the halt write
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | counter runs, RAM/GPIO/HALT writes take effect
// HALT  | sticky until reset; writes ignored, counter frozen, reads ok
module data_mem_mmio
  import mem_map_pkg::*;
#(
  parameter int unsigned WORDS       = 256,
  parameter logic [3:0]  MMIO_NIBBLE = MMIO_NIBBLE_DEF
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [31:0] gpio_out,
  output logic        halted,
  output logic [31:0] halt_code
);

  localparam int unsigned AW = $clog2(WORDS);

  halt_state_t state_q;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] gpio_q;
  logic [31:0] halt_code_q;

  logic          mmio_sel;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          mmio_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;
  logic          unused_addr;

  assign mmio_sel = (dataAddr[31:28] == MMIO_NIBBLE);
  assign reg_sel  = dataAddr[3:2];
  assign ram_idx  = dataAddr[AW+1:2];

  // Address bits outside the decoded fields alias by design.
  assign unused_addr = ^dataAddr;

  // The RAM has no reset of its own, so the reset level is folded into its
  // strobe: an edge seen while n_reset is low must not write.
  assign ram_we  = we & ~mmio_sel & n_reset & (state_q == RUN);
  assign mmio_we = we & mmio_sel;

  assign cycle_d = cycle_q + 32'd1;

  data_ram #(
    .WORDS (WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_idx),
    .wdata (writeData),
    .raddr (ram_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    mmio_rdata = 32'd0;
    case (reg_sel)
      REG_CYCLE: mmio_rdata = cycle_q;
      REG_GPIO:  mmio_rdata = gpio_q;
      REG_HALT:  mmio_rdata = halt_code_q;
      default:   mmio_rdata = 32'd0;
    endcase
  end

  assign readData = mmio_sel ? mmio_rdata : ram_rdata;

  // The counter advances on the halting edge too and freezes from then on.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= RUN;
      cycle_q     <= 32'd0;
      gpio_q      <= 32'd0;
      halt_code_q <= 32'd0;
    end else begin
      case (state_q)
        RUN: begin
          cycle_q <= cycle_d;
          if (mmio_we) begin
            case (reg_sel)
              REG_GPIO: gpio_q <= writeData;
              REG_HALT: begin
                halt_code_q <= writeData;
                state_q     <= HALT;
              end
              default: ;
            endcase
          end
        end
        HALT: ;
        default: state_q <= HALT;
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign halted    = (state_q == HALT);
  assign halt_code = halt_code_q;

endmodule
